// File: rtl/memwb_skid.sv
// rtl/memwb_skid.sv - MEM/WB write-back register with valid/ready handshake and 2-entry skid buffer
module memwb_skid #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter bit ZERO_SUPPRESS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_wr_data,
    input  logic [ADDR_W-1:0] in_wr_address,
    input  logic              in_wr_enable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_wr_data,
    output logic [ADDR_W-1:0] out_wr_address,
    output logic              out_wr_enable,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [ADDR_W-1:0]   main_addr_q, main_addr_d;
    logic                main_en_q, main_en_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [ADDR_W-1:0]   skid_addr_q, skid_addr_d;
    logic                skid_en_q, skid_en_d;
    logic                in_ready_q, in_ready_d;

    logic accept;
    logic drain;
    logic cap_en;

    assign accept = in_valid & in_ready_q & ~flush;
    assign drain  = (state_q != S_EMPTY) & out_ready;
    // Writes to $zero are architecturally discarded, so drop the enable at capture time.
    assign cap_en = in_wr_enable & ~(ZERO_SUPPRESS & (in_wr_address == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b0;
            main_data_q <= '0;
            main_addr_q <= '0;
            main_en_q   <= 1'b0;
            skid_data_q <= '0;
            skid_addr_q <= '0;
            skid_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_addr_q <= main_addr_d;
            main_en_q   <= main_en_d;
            skid_data_q <= skid_data_d;
            skid_addr_q <= skid_addr_d;
            skid_en_q   <= skid_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_addr_d = main_addr_q;
        main_en_d   = main_en_q;
        skid_data_d = skid_data_q;
        skid_addr_d = skid_addr_q;
        skid_en_d   = skid_en_q;

        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_data_d = in_wr_data;
                    main_addr_d = in_wr_address;
                    main_en_d   = cap_en;
                    state_d     = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && drain) begin
                    main_data_d = in_wr_data;
                    main_addr_d = in_wr_address;
                    main_en_d   = cap_en;
                end else if (accept) begin
                    skid_data_d = in_wr_data;
                    skid_addr_d = in_wr_address;
                    skid_en_d   = cap_en;
                    state_d     = S_TWO;
                end else if (drain) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (drain) begin
                    main_data_d = skid_data_q;
                    main_addr_d = skid_addr_q;
                    main_en_d   = skid_en_q;
                    state_d     = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // Flush keeps payloads but kills every enable so no stale write can escape.
        if (flush) begin
            state_d     = S_EMPTY;
            main_data_d = main_data_q;
            main_addr_d = main_addr_q;
            main_en_d   = 1'b0;
            skid_data_d = skid_data_q;
            skid_addr_d = skid_addr_q;
            skid_en_d   = 1'b0;
        end

        in_ready_d = (state_d != S_TWO);
    end

    always_comb begin
        out_valid      = (state_q != S_EMPTY);
        out_wr_data    = main_data_q;
        out_wr_address = main_addr_q;
        out_wr_enable  = main_en_q & (state_q != S_EMPTY);
        in_ready       = in_ready_q;
        case (state_q)
            S_ONE:   occupancy = 2'd1;
            S_TWO:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_memwb_skid.sv
// tb/tb_memwb_skid.sv - scoreboard bench for memwb_skid, suppressing and non-suppressing instances
module tb_memwb_skid;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready, in_wr_enable;
    logic [31:0] in_wr_data;
    logic [4:0]  in_wr_address;

    logic        in_ready, out_valid, out_wr_enable;
    logic [31:0] out_wr_data;
    logic [4:0]  out_wr_address;
    logic [1:0]  occupancy;

    logic        nz_in_ready, nz_out_valid, nz_out_wr_enable;
    logic [31:0] nz_out_wr_data;
    logic [4:0]  nz_out_wr_address;
    logic [1:0]  nz_occupancy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  a;
        logic        e;
    } rec_t;

    rec_t sb[$];
    logic irdy_m    = 1'b0;
    logic zero_flag = 1'b1;

    always #5 clk = ~clk;

    memwb_skid #(.DATA_W(32), .ADDR_W(5), .ZERO_SUPPRESS(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wr_data(in_wr_data), .in_wr_address(in_wr_address), .in_wr_enable(in_wr_enable),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wr_data(out_wr_data), .out_wr_address(out_wr_address), .out_wr_enable(out_wr_enable),
        .occupancy(occupancy)
    );

    memwb_skid #(.DATA_W(32), .ADDR_W(5), .ZERO_SUPPRESS(1'b0)) u_nz (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(nz_in_ready),
        .in_wr_data(in_wr_data), .in_wr_address(in_wr_address), .in_wr_enable(in_wr_enable),
        .out_valid(nz_out_valid), .out_ready(out_ready),
        .out_wr_data(nz_out_wr_data), .out_wr_address(nz_out_wr_address), .out_wr_enable(nz_out_wr_enable),
        .occupancy(nz_occupancy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs are compared at the falling edge; the model is then advanced to the next rising edge.
    always @(negedge clk) begin
        rec_t r;
        logic acc, drn;
        check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
        check("occupancy", {30'd0, occupancy}, sb.size());
        check("in_ready", {31'd0, in_ready}, {31'd0, irdy_m});
        check("nz_out_valid", {31'd0, nz_out_valid}, {31'd0, sb.size() > 0});
        check("nz_occupancy", {30'd0, nz_occupancy}, sb.size());
        check("nz_in_ready", {31'd0, nz_in_ready}, {31'd0, irdy_m});
        if (sb.size() > 0) begin
            r = sb[0];
            check("head_data", out_wr_data, r.d);
            check("head_addr", {27'd0, out_wr_address}, {27'd0, r.a});
            check("head_en", {31'd0, out_wr_enable}, {31'd0, r.e && (r.a != 5'd0)});
            check("nz_head_data", nz_out_wr_data, r.d);
            check("nz_head_addr", {27'd0, nz_out_wr_address}, {27'd0, r.a});
            check("nz_head_en", {31'd0, nz_out_wr_enable}, {31'd0, r.e});
        end else begin
            check("idle_en", {31'd0, out_wr_enable}, 32'd0);
            check("nz_idle_en", {31'd0, nz_out_wr_enable}, 32'd0);
            if (zero_flag) begin
                check("reset_data", out_wr_data, 32'd0);
                check("reset_addr", {27'd0, out_wr_address}, 32'd0);
            end
        end

        if (!rst_n) begin
            sb.delete();
            irdy_m    = 1'b0;
            zero_flag = 1'b1;
        end else if (flush) begin
            sb.delete();
            irdy_m = 1'b1;
        end else begin
            acc = in_valid && irdy_m;
            drn = (sb.size() > 0) && out_ready;
            if (drn) void'(sb.pop_front());
            if (acc) begin
                r.d = in_wr_data;
                r.a = in_wr_address;
                r.e = in_wr_enable;
                sb.push_back(r);
                zero_flag = 1'b0;
            end
            irdy_m = (sb.size() != 2);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic v, input logic [31:0] d, input logic [4:0] a, input logic e);
        in_valid      = v;
        in_wr_data    = d;
        in_wr_address = a;
        in_wr_enable  = e;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        put(1'b0, 32'd0, 5'd0, 1'b0);
        step(); step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_wr_data, 32'd0);
        rst_n = 1'b1;
        step();
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        out_ready = 1'b1;
        put(1'b1, 32'h11, 5'd1, 1'b1); step();
        check("stream_11", out_wr_data, 32'h11);
        put(1'b1, 32'h22, 5'd2, 1'b1); step();
        check("stream_22", out_wr_data, 32'h22);
        put(1'b1, 32'h33, 5'd3, 1'b1); step();
        check("stream_33", out_wr_data, 32'h33);
        put(1'b0, 32'h0, 5'd0, 1'b0); step();
        check("stream_end_valid", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b0;
        put(1'b1, 32'hA0, 5'd4, 1'b1); step();
        put(1'b1, 32'hA1, 5'd5, 1'b1); step();
        put(1'b1, 32'hA2, 5'd6, 1'b1); step();
        check("bp_occ", {30'd0, occupancy}, 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_head", out_wr_data, 32'hA0);
        step();
        check("bp_head_hold", out_wr_data, 32'hA0);
        out_ready = 1'b1; step();
        check("bp_drain_a1", out_wr_data, 32'hA1);
        check("bp_drain_rdy", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_drain_a2", out_wr_data, 32'hA2);
        put(1'b0, 32'h0, 5'd0, 1'b0); step();

        out_ready = 1'b0;
        put(1'b1, 32'hDEAD, 5'd0, 1'b1); step();
        put(1'b0, 32'h0, 5'd0, 1'b0);
        check("zs_valid", {31'd0, out_valid}, 32'd1);
        check("zs_en", {31'd0, out_wr_enable}, 32'd0);
        check("nz_en", {31'd0, nz_out_wr_enable}, 32'd1);
        out_ready = 1'b1; step();

        out_ready = 1'b0;
        put(1'b1, 32'h44, 5'd7, 1'b1); step();
        out_ready = 1'b1;
        put(1'b1, 32'h55, 5'd8, 1'b1); step();
        check("one_ad_head", out_wr_data, 32'h55);
        check("one_ad_occ", {30'd0, occupancy}, 32'd1);
        check("one_ad_rdy", {31'd0, in_ready}, 32'd1);
        put(1'b0, 32'h0, 5'd0, 1'b0); step();

        out_ready = 1'b0;
        put(1'b1, 32'h66, 5'd9, 1'b1); step();
        put(1'b1, 32'h77, 5'd10, 1'b1); step();
        check("pre_flush_occ", {30'd0, occupancy}, 32'd2);
        put(1'b1, 32'hBB, 5'd11, 1'b1); flush = 1'b1; step();
        flush = 1'b0; put(1'b0, 32'h0, 5'd0, 1'b0);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_en", {31'd0, out_wr_enable}, 32'd0);
        check("flush_occ", {30'd0, occupancy}, 32'd0);
        check("flush_rdy", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1; step(); step();

        for (int i = 0; i < 10000; i++) begin
            put(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 99) < 2);
            step();
        end
        put(1'b0, 32'h0, 5'd0, 1'b0); flush = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        check("final_empty", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memwb_skid.md
# memwb_skid

Parametrised successor to the MEM/WB pipeline register of the Jahangir MIPS32 pipeline. It carries the write-back triple (data, destination register, write enable) from stage 4 to the register file. It adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, and optional suppression of writes to register $zero. This lets a stalled write-back port hold off stage 4 without a combinational ready path.

## Interface
- DATA_W, 32, width of write-back data
- ADDR_W, 5, width of destination register address
- ZERO_SUPPRESS, 1, when 1, an entry captured with in_wr_address == 0 stores wr_enable = 0
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  registered; block can accept an entry this cycle
- in_wr_data  in  DATA_W  write-back data
- in_wr_address  in  ADDR_W  destination register
- in_wr_enable  in  1  register-file write request
- out_valid  out  1  head entry present
- out_ready  in  1  downstream consumes the head entry this cycle
- out_wr_data  out  DATA_W  head entry data
- out_wr_address  out  ADDR_W  head entry address
- out_wr_enable  out  1  head entry write enable; forced 0 whenever out_valid = 0
- occupancy  out  2  number of held entries (0, 1 or 2)

## Operation
- Storage: main slot, which drives the out_* ports, and skid slot. Each slot holds {data, address, enable}.
- accept = in_valid & in_ready & !flush. drain = out_valid & out_ready.
- Captured enable = in_wr_enable & !(ZERO_SUPPRESS & in_wr_address == 0).
- State machine, states EMPTY / ONE / TWO:
  - EMPTY: on accept, main <= in and go to ONE. Otherwise stay in EMPTY.
  - ONE, accept & drain: main <= in, stay in ONE.
  - ONE, accept & !drain: skid <= in, go to TWO.
  - ONE, !accept & drain: go to EMPTY.
  - ONE, neither: hold.
  - TWO: on drain, main <= skid and go to ONE. Otherwise hold. in_ready is 0, so accept is impossible.
- Output mapping:
  - out_valid = (state != EMPTY).
  - occupancy: EMPTY = 0, ONE = 1, TWO = 2.
  - in_ready register <= (next_state != TWO). It never depends combinationally on out_ready.
- flush (priority below reset, above everything else):
  - Next state is EMPTY.
  - in_ready register <= 1.
  - Inputs presented that cycle are dropped.
  - Slot data and address hold their last values; enables are cleared to 0.
- Ordering: entries leave in strict arrival order. No entry is duplicated or lost except by flush or reset.
- Head hold: while out_valid & !out_ready, all out_* ports are stable.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - state EMPTY, out_valid 0, out_wr_data 0, out_wr_address 0, out_wr_enable 0, occupancy 0.
  - in_ready 0, and skid slot cleared.
  - in_ready rises to 1 at the first edge with rst_n = 1.
- Reset mid-operation discards all entries the same as flush, but also zeroes the data and address fields.
- Latency: an entry accepted at edge N is visible on out_* after edge N (registered, 1 cycle) when the block was EMPTY, or ONE with a simultaneous drain.
- Throughput: one entry per cycle sustained while out_ready = 1.
- Backpressure: after out_ready drops, at most one further entry is accepted (into the skid slot); in_ready is 0 from the following cycle.
- Full-to-drain: in TWO, a drain at edge N presents the skid entry on out_* after edge N, and in_ready = 1 after edge N.
- flush and drain in the same cycle: the flush wins and the head is considered consumed. Downstream is not required to distinguish the two.

## Test plan
- Reset then stream: hold rst_n = 0 for 2 cycles, release, then present data 0x11, 0x22, 0x33 (addr 1, 2, 3, en 1) with out_ready = 1.
  - All outputs are 0 during reset and in_ready = 0 until the first edge after release.
  - Outputs appear one cycle after acceptance, back-to-back, in order.
- Backpressure fill: out_ready = 0 with a continuous in_valid stream of 0xA0, 0xA1, 0xA2.
  - 0xA0 and 0xA1 are accepted and occupancy reaches 2; in_ready = 0 and 0xA2 is held upstream.
  - out_wr_data stays 0xA0.
  - Raise out_ready: the sequence 0xA0, 0xA1, 0xA2 is delivered with no gap.
- Zero suppression: with ZERO_SUPPRESS = 1, present addr 0, en 1, data 0xDEAD → out_wr_enable = 0 and out_valid = 1. With ZERO_SUPPRESS = 0 the same stimulus gives out_wr_enable = 1.
- Flush while full: in state TWO, assert flush together with in_valid (data 0xBB).
  - Next cycle: out_valid = 0, out_wr_enable = 0, occupancy = 0, in_ready = 1, and 0xBB is never output.
- Simultaneous accept and drain in ONE: present 0x55 while the head is 0x44 and out_ready = 1.
  - Next cycle the head is 0x55, occupancy stays 1, and in_ready stays 1.
- Random soak: 10k cycles of random in_valid, out_ready and flush at 2%.
  - A scoreboard checks strict ordering, no loss outside flush, and stable outputs under stall.
